planificador_ascensor: RTL and testbench
========================================

// Module: planificador_ascensor
// PURPOSE
//   Cabin scheduler for the 4-floor elevator. Latches hall/cabin button pulses into a
//   pending-request register, picks the travel direction (collective, keeps current
//   direction while requests remain ahead), drives the motor and stops at served floors.
//   Hands each stop to CONTROL_PUERTAS via pisos/estado and waits on its trabajando.
// PARAMETERS
//   T_MAX_VIAJE    1000  max cycles between llegada pulses while moving before FALLA
//   T_ESPERA_PTAS  8     max cycles in PUERTAS waiting for trabajando to rise
//   ANCHO_CNT      10    width of shared cycle counter (must hold T_MAX_VIAJE)
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   reset        in   1   synchronous, active-high
//   botones      in   10  1-cycle press pulses, same encoding as pisos
//   llegada      in   1   1-cycle pulse: cabin reached next floor in motor direction
//   trabajando   in   1   from CONTROL_PUERTAS: door sequence in progress
//   pisos        out  10  pending requests (registered); [6..9] cabin f0..f3,
//                         [0] f0 up, [1] f1 up, [2] f1 down, [3] f2 up, [4] f2 down, [5] f3 down
//   estado       out  4   {mov, bajando, f[0], f[1]}: [3] moving, [2] 1=down,
//                         [0] floor MSB, [1] floor LSB (floor = {estado[0],estado[1]})
//   motor        out  2   01 up, 10 down, 00 stop; 11 never driven
//   falla        out  1   sticky fault flag
// BEHAVIOUR
//   Reset: state REPOSO, pisos=0, estado=4'b0000 (floor 0, up, stopped), motor=00,
//     falla=0, counter=0. Reset mid-travel behaves identically (no position recovery).
//   All outputs registered; 1-cycle latency from decision to outputs.
//   Request latch: pisos <= (pisos | botones) & ~limpiar. Clear wins over a press of
//     the same bit in the same cycle. botones ignored in FALLA.
//   "Served at f, dir d": cabin bit f + hall bit f in dir d; at f0 also [0], at f3 also [5];
//     opposite hall bit of f too if no pending request beyond f in dir d.
//   Stop condition at f (moving dir d): served bit set at f, or f terminal (0/3).
//   FSM:
//   REPOSO: motor=00, mov=0. Priority, evaluated each cycle on pisos:
//     served request at current floor -> PUERTAS; else request ahead in estado[2] dir ->
//     SUBIENDO/BAJANDO; else request in opposite dir -> flip estado[2], go that way;
//     else stay. counter=0 on exit.
//   SUBIENDO/BAJANDO: motor=01/10, mov=1, counter++ per cycle.
//     llegada: floor +/-1 (counter=0); if stop condition at new floor -> PUERTAS (motor=00
//     next cycle), else keep moving. llegada while at f3 up / f0 down -> FALLA.
//     counter == T_MAX_VIAJE-1 without llegada -> FALLA.
//   PUERTAS: motor=00, mov=0, pisos held (door block sees request). Sub-phases:
//     ESPERA: trabajando=1 -> ACTIVO; counter reaches T_ESPERA_PTAS-1 -> clear served bits,
//       REPOSO. ACTIVO: on trabajando 1->0 apply limpiar for (floor, dir) -> REPOSO.
//     llegada in REPOSO/PUERTAS ignored.
//   FALLA: motor=00, mov=0, falla=1, pisos frozen; exit only by reset.
//   Floor arithmetic 2-bit, never wraps (terminal cases go to FALLA as above).
// TESTING
//   1 reset; botones[8] pulse (cabin f2) -> motor=01 next cycle; 2 llegada -> estado=4'b0001
//     (f2, up, stopped), motor=00; trabajando 1 then 0 -> pisos[8]=0, state REPOSO.
//   2 at f1 idle, press [0] and [9] same cycle, dir up -> go up to f3 first, then down to f0;
//     pisos returns to 0 after both door cycles.
//   3 moving up from f0 with [4] (f2 down) only -> passes f1, stops f2, clears [4].
//   4 motor=01, no llegada for T_MAX_VIAJE cycles -> falla=1, motor=00; further botones
//     ignored; reset -> all outputs 0.
//   5 in PUERTAS-ACTIVO, press same bit as being cleared on trabajando fall -> bit ends 0;
//     press other bit that cycle -> latched.
//   6 stop at requested floor, trabajando never rises -> after T_ESPERA_PTAS cycles bits
//     cleared, REPOSO.

Source files
------------

// File: rtl/planificador_ascensor_if.sv
// Handshake bundle between the elevator scheduler, button panel, floor sensor and door controller.
interface planificador_ascensor_if;
    logic [9:0] botones;
    logic       llegada;
    logic       trabajando;
    logic [9:0] pisos;
    logic [3:0] estado;
    logic [1:0] motor;
    logic       falla;

    modport master (
        output botones, llegada, trabajando,
        input  pisos, estado, motor, falla
    );

    modport slave (
        input  botones, llegada, trabajando,
        output pisos, estado, motor, falla
    );
endinterface

// File: rtl/planificador_ascensor.sv
// Collective cabin scheduler for a 4-floor elevator: latches requests, picks direction,
// drives the motor and hands each stop to the door controller.
module planificador_ascensor #(
    parameter int unsigned T_MAX_VIAJE   = 1000,
    parameter int unsigned T_ESPERA_PTAS = 8,
    parameter int unsigned ANCHO_CNT     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    planificador_ascensor_if.slave bus
);
    localparam logic [ANCHO_CNT-1:0] CNT_VIAJE  = ANCHO_CNT'(T_MAX_VIAJE - 1);
    localparam logic [ANCHO_CNT-1:0] CNT_ESPERA = ANCHO_CNT'(T_ESPERA_PTAS - 1);

    typedef enum logic [2:0] {
        REPOSO,
        SUBIENDO,
        BAJANDO,
        PUERTAS_ESPERA,
        PUERTAS_ACTIVO,
        FALLA
    } estado_t;

    estado_t              st;
    logic [9:0]           pisos_q;
    logic [1:0]           piso_q;
    logic                 bajando_q;
    logic                 mov_q;
    logic [1:0]           motor_q;
    logic                 falla_q;
    logic [ANCHO_CNT-1:0] cnt_q;

    logic [9:0] serv_aqui;
    logic [9:0] limpiar;
    logic       adelante;
    logic       atras;
    logic [1:0] piso_sig;
    logic       en_extremo;
    logic       parada_sig;

    function automatic logic [9:0] cabina(input logic [1:0] f);
        case (f)
            2'd0:    return 10'h040;
            2'd1:    return 10'h080;
            2'd2:    return 10'h100;
            default: return 10'h200;
        endcase
    endfunction

    function automatic logic [9:0] hall_sube(input logic [1:0] f);
        case (f)
            2'd0:    return 10'h001;
            2'd1:    return 10'h002;
            2'd2:    return 10'h008;
            default: return 10'h000;
        endcase
    endfunction

    function automatic logic [9:0] hall_baja(input logic [1:0] f);
        case (f)
            2'd1:    return 10'h004;
            2'd2:    return 10'h010;
            2'd3:    return 10'h020;
            default: return 10'h000;
        endcase
    endfunction

    // Any pending request strictly beyond floor f in the given direction.
    function automatic logic mas_alla(input logic [9:0] p, input logic [1:0] f, input logic baja);
        logic r;
        r = 1'b0;
        for (int g = 0; g < 4; g++) begin
            if (baja ? (2'(g) < f) : (2'(g) > f))
                r = r | (|(p & (cabina(2'(g)) | hall_sube(2'(g)) | hall_baja(2'(g)))));
        end
        return r;
    endfunction

    // Bits answered by a stop at floor f travelling in the given direction.
    function automatic logic [9:0] servidos(input logic [9:0] p, input logic [1:0] f, input logic baja);
        logic [9:0] m;
        m = cabina(f) | (baja ? hall_baja(f) : hall_sube(f));
        if (f == 2'd0)
            m = m | 10'h001;
        if (f == 2'd3)
            m = m | 10'h020;
        if (!mas_alla(p, f, baja))
            m = m | (baja ? hall_sube(f) : hall_baja(f));
        return m;
    endfunction

    always_comb begin
        serv_aqui  = servidos(pisos_q, piso_q, bajando_q);
        adelante   = mas_alla(pisos_q, piso_q, bajando_q);
        atras      = mas_alla(pisos_q, piso_q, !bajando_q);
        piso_sig   = bajando_q ? (piso_q - 2'd1) : (piso_q + 2'd1);
        en_extremo = bajando_q ? (piso_q == 2'd0) : (piso_q == 2'd3);
        parada_sig = (piso_sig == 2'd0) || (piso_sig == 2'd3)
                     || (|(pisos_q & servidos(pisos_q, piso_sig, bajando_q)));
        limpiar    = '0;
        if (((st == PUERTAS_ESPERA) && !bus.trabajando && (cnt_q == CNT_ESPERA))
            || ((st == PUERTAS_ACTIVO) && !bus.trabajando))
            limpiar = serv_aqui;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= REPOSO;
            pisos_q   <= '0;
            piso_q    <= 2'd0;
            bajando_q <= 1'b0;
            mov_q     <= 1'b0;
            motor_q   <= 2'b00;
            falla_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // A clear beats a press of the same bit in the same cycle.
            if (st != FALLA)
                pisos_q <= (pisos_q | bus.botones) & ~limpiar;

            case (st)
                REPOSO: begin
                    cnt_q <= '0;
                    if (|(pisos_q & serv_aqui)) begin
                        st <= PUERTAS_ESPERA;
                    end else if (adelante) begin
                        st      <= bajando_q ? BAJANDO : SUBIENDO;
                        mov_q   <= 1'b1;
                        motor_q <= bajando_q ? 2'b10 : 2'b01;
                    end else if (atras) begin
                        bajando_q <= !bajando_q;
                        st        <= bajando_q ? SUBIENDO : BAJANDO;
                        mov_q     <= 1'b1;
                        motor_q   <= bajando_q ? 2'b01 : 2'b10;
                    end
                end

                SUBIENDO, BAJANDO: begin
                    if (bus.llegada) begin
                        cnt_q <= '0;
                        if (en_extremo) begin
                            st      <= FALLA;
                            mov_q   <= 1'b0;
                            motor_q <= 2'b00;
                            falla_q <= 1'b1;
                        end else begin
                            piso_q <= piso_sig;
                            if (parada_sig) begin
                                st      <= PUERTAS_ESPERA;
                                mov_q   <= 1'b0;
                                motor_q <= 2'b00;
                            end
                        end
                    end else if (cnt_q == CNT_VIAJE) begin
                        st      <= FALLA;
                        mov_q   <= 1'b0;
                        motor_q <= 2'b00;
                        falla_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end

                PUERTAS_ESPERA: begin
                    if (bus.trabajando) begin
                        st <= PUERTAS_ACTIVO;
                    end else if (cnt_q == CNT_ESPERA) begin
                        st    <= REPOSO;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + ANCHO_CNT'(1);
                    end
                end

                PUERTAS_ACTIVO: begin
                    if (!bus.trabajando)
                        st <= REPOSO;
                end

                FALLA: begin
                    mov_q   <= 1'b0;
                    motor_q <= 2'b00;
                    falla_q <= 1'b1;
                end

                default: begin
                    st      <= REPOSO;
                    mov_q   <= 1'b0;
                    motor_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.pisos  = pisos_q;
    assign bus.estado = {mov_q, bajando_q, piso_q[0], piso_q[1]};
    assign bus.motor  = motor_q;
    assign bus.falla  = falla_q;
endmodule

// File: tb/tb_planificador_ascensor.sv
// Bench for planificador_ascensor: fixed vectors, directed corner sequences and a random run
// checked against a floor/request-set model of the scheduler.
module tb_planificador_ascensor;
    localparam int T_MAX = 1000;
    localparam int T_ESP = 8;
    localparam int M_REPOSO = 0, M_MUEVE = 1, M_ESPERA = 2, M_ACTIVO = 3, M_FALLA = 4;

    logic clk = 1'b0;
    logic reset;
    planificador_ascensor_if bus();

    planificador_ascensor #(
        .T_MAX_VIAJE  (T_MAX),
        .T_ESPERA_PTAS(T_ESP),
        .ANCHO_CNT    (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int         m_modo;
    int         m_piso;
    int         m_cnt;
    bit         m_baja;
    bit         m_falla;
    logic [9:0] m_pisos;
    int         paradas[$];

    typedef struct {
        logic [9:0] b;
        bit         l;
        bit         t;
        logic [9:0] p;
        logic [3:0] e;
        logic [1:0] m;
    } vec_t;
    vec_t tabla[9];

    function automatic logic [9:0] bit_de(input int i);
        if (i < 0)
            return 10'd0;
        return 10'(1) << i;
    endfunction

    function automatic int idx_sube(input int f);
        case (f)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int idx_baja(input int f);
        case (f)
            1:       return 2;
            2:       return 4;
            3:       return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] todos_en(input int f);
        return bit_de(6 + f) | bit_de(idx_sube(f)) | bit_de(idx_baja(f));
    endfunction

    function automatic bit hay_mas_alla(input logic [9:0] p, input int f, input bit baja);
        for (int g = 0; g < 4; g++)
            if ((baja ? (g < f) : (g > f)) && ((p & todos_en(g)) != 10'd0))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] atendidos(input logic [9:0] p, input int f, input bit baja);
        logic [9:0] m;
        m = bit_de(6 + f) | bit_de(baja ? idx_baja(f) : idx_sube(f));
        if (f == 0) m = m | bit_de(0);
        if (f == 3) m = m | bit_de(5);
        if (!hay_mas_alla(p, f, baja))
            m = m | bit_de(baja ? idx_sube(f) : idx_baja(f));
        return m;
    endfunction

    function automatic logic [16:0] esperado();
        logic [1:0] fb;
        logic [1:0] mot;
        fb  = 2'(m_piso);
        mot = (m_modo == M_MUEVE) ? (m_baja ? 2'b10 : 2'b01) : 2'b00;
        return {m_pisos, (m_modo == M_MUEVE), m_baja, fb[0], fb[1], mot, m_falla};
    endfunction

    task automatic m_paso(input logic [9:0] b, input bit l, input bit t);
        logic [9:0] serv;
        logic [9:0] lim;
        bit         congelado;
        int         nuevo;
        congelado = (m_modo == M_FALLA);
        serv = atendidos(m_pisos, m_piso, m_baja);
        lim  = 10'd0;
        case (m_modo)
            M_REPOSO: begin
                if ((m_pisos & serv) != 10'd0) begin
                    m_modo = M_ESPERA; m_cnt = 0; paradas.push_back(m_piso);
                end else if (hay_mas_alla(m_pisos, m_piso, m_baja)) begin
                    m_modo = M_MUEVE; m_cnt = 0;
                end else if (hay_mas_alla(m_pisos, m_piso, !m_baja)) begin
                    m_baja = !m_baja; m_modo = M_MUEVE; m_cnt = 0;
                end
            end
            M_MUEVE: begin
                if (l) begin
                    if ((m_baja && m_piso == 0) || (!m_baja && m_piso == 3)) begin
                        m_modo = M_FALLA; m_falla = 1'b1;
                    end else begin
                        nuevo = m_baja ? m_piso - 1 : m_piso + 1;
                        m_cnt = 0;
                        if (nuevo == 0 || nuevo == 3
                            || (m_pisos & atendidos(m_pisos, nuevo, m_baja)) != 10'd0) begin
                            m_modo = M_ESPERA; paradas.push_back(nuevo);
                        end
                        m_piso = nuevo;
                    end
                end else if (m_cnt == T_MAX - 1) begin
                    m_modo = M_FALLA; m_falla = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            M_ESPERA: begin
                if (t) m_modo = M_ACTIVO;
                else if (m_cnt == T_ESP - 1) begin
                    lim = serv; m_modo = M_REPOSO; m_cnt = 0;
                end else m_cnt++;
            end
            M_ACTIVO: begin
                if (!t) begin lim = serv; m_modo = M_REPOSO; end
            end
            default: ;
        endcase
        if (!congelado)
            m_pisos = (m_pisos | b) & ~lim;
    endtask

    task automatic comparar(input string nombre, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nombre, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] salidas();
        return {bus.pisos, bus.estado, bus.motor, bus.falla};
    endfunction

    task automatic ciclo(input logic [9:0] b, input bit l, input bit t);
        bus.botones = b; bus.llegada = l; bus.trabajando = t;
        @(posedge clk);
        m_paso(b, l, t);
        #1;
        comparar("modelo", salidas(), esperado());
    endtask

    task automatic reiniciar();
        reset = 1'b1;
        bus.botones = '0; bus.llegada = 1'b0; bus.trabajando = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_modo = M_REPOSO; m_pisos = '0; m_piso = 0; m_baja = 1'b0;
        m_cnt = 0; m_falla = 1'b0;
        paradas.delete();
        comparar("reset", salidas(), 17'd0);
    endtask

    // Runs the cabin with periodic llegada and short door cycles until everything is served.
    task automatic conducir(input int max_ciclos);
        int d;
        bit tr;
        bit l;
        bit listo;
        d = 0; tr = 1'b0; listo = 1'b0;
        for (int i = 0; i < max_ciclos; i++) begin
            l = (m_modo == M_MUEVE) && (i % 3 == 2);
            if (m_modo == M_ESPERA) begin tr = 1'b1; d = 0; end
            else if (m_modo == M_ACTIVO) begin d++; if (d >= 2) tr = 1'b0; end
            else tr = 1'b0;
            ciclo('0, l, tr);
            if (m_modo == M_REPOSO && m_pisos == 10'd0) begin listo = 1'b1; break; end
        end
        comparar("conducir_limite", {16'd0, listo}, 17'd1);
    endtask

    initial begin
        int n;
        bit tr;
        logic [9:0] b;

        tabla[0] = '{10'h100, 1'b0, 1'b0, 10'h100, 4'b0000, 2'b00};
        tabla[1] = '{10'h000, 1'b0, 1'b0, 10'h100, 4'b1000, 2'b01};
        tabla[2] = '{10'h000, 1'b1, 1'b0, 10'h100, 4'b1010, 2'b01};
        tabla[3] = '{10'h000, 1'b0, 1'b0, 10'h100, 4'b1010, 2'b01};
        tabla[4] = '{10'h000, 1'b1, 1'b0, 10'h100, 4'b0001, 2'b00};
        tabla[5] = '{10'h000, 1'b0, 1'b1, 10'h100, 4'b0001, 2'b00};
        tabla[6] = '{10'h000, 1'b0, 1'b1, 10'h100, 4'b0001, 2'b00};
        tabla[7] = '{10'h000, 1'b0, 1'b0, 10'h000, 4'b0001, 2'b00};
        tabla[8] = '{10'h000, 1'b0, 1'b0, 10'h000, 4'b0001, 2'b00};

        reiniciar();
        for (int i = 0; i < 9; i++) begin
            ciclo(tabla[i].b, tabla[i].l, tabla[i].t);
            comparar($sformatf("tabla%0d", i), salidas(), {tabla[i].p, tabla[i].e, tabla[i].m, 1'b0});
        end

        // Idle at f1 going up, f0-up and cabin-f3 pressed together: f3 first, then f0.
        reiniciar();
        ciclo(10'h080, 1'b0, 1'b0);
        conducir(80);
        paradas.delete();
        ciclo(10'h201, 1'b0, 1'b0);
        conducir(150);
        comparar("colectivo_nparadas", 17'(paradas.size()), 17'd2);
        if (paradas.size() == 2) begin
            comparar("colectivo_primera", 17'(paradas[0]), 17'd3);
            comparar("colectivo_segunda", 17'(paradas[1]), 17'd0);
        end
        comparar("colectivo_final", salidas(), {10'h000, 4'b0100, 2'b00, 1'b0});

        // f2-down request from f0: passes f1, stops at f2.
        reiniciar();
        ciclo(10'h010, 1'b0, 1'b0);
        conducir(80);
        comparar("paso_nparadas", 17'(paradas.size()), 17'd1);
        if (paradas.size() == 1)
            comparar("paso_piso", 17'(paradas[0]), 17'd2);
        comparar("paso_final", salidas(), {10'h000, 4'b0001, 2'b00, 1'b0});

        // Travel timeout: exactly T_MAX cycles of motion without llegada.
        reiniciar();
        ciclo(10'h200, 1'b0, 1'b0);
        ciclo('0, 1'b0, 1'b0);
        comparar("viaje_motor", {15'd0, bus.motor}, 17'd1);
        n = 0;
        while (n < T_MAX + 20 && bus.falla !== 1'b1) begin
            ciclo('0, 1'b0, 1'b0);
            n++;
        end
        comparar("viaje_ciclos", 17'(n), 17'(T_MAX));
        comparar("viaje_falla", salidas(), {10'h200, 4'b0000, 2'b00, 1'b1});
        ciclo(10'h3FF, 1'b0, 1'b0);
        comparar("falla_congelada", salidas(), {10'h200, 4'b0000, 2'b00, 1'b1});
        reiniciar();

        // Clear wins over same-bit press on trabajando fall; other bit latches.
        reiniciar();
        ciclo(10'h040, 1'b0, 1'b0);
        ciclo('0, 1'b0, 1'b0);
        ciclo('0, 1'b0, 1'b1);
        ciclo('0, 1'b0, 1'b1);
        ciclo(10'h048, 1'b0, 1'b0);
        comparar("limpiar_gana", {7'd0, bus.pisos}, {7'd0, 10'h008});

        // Door controller never answers: bits cleared after T_ESP cycles in PUERTAS.
        reiniciar();
        ciclo(10'h080, 1'b0, 1'b0);
        ciclo('0, 1'b0, 1'b0);
        comparar("espera_motor", {15'd0, bus.motor}, 17'd1);
        ciclo('0, 1'b1, 1'b0);
        comparar("espera_parada", salidas(), {10'h080, 4'b0010, 2'b00, 1'b0});
        n = 0;
        while (n < T_ESP + 10 && bus.pisos[7] !== 1'b0) begin
            ciclo('0, 1'b0, 1'b0);
            n++;
        end
        comparar("espera_ciclos", 17'(n), 17'(T_ESP));

        // Random traffic against the model.
        reiniciar();
        tr = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? bit_de(int'($urandom_range(0, 9))) : 10'd0;
            if ($urandom_range(0, 3) == 0) tr = !tr;
            ciclo(b, ($urandom_range(0, 7) == 0), tr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
